// File: rtl/f_division.sv
// Integer clock divider: clk_out runs at clk_in/DIV with exactly 50% duty.
// Even ratios use a rising-edge phase flop; odd ratios add a falling-edge flop.
module f_division #(
  parameter int DIV = 4
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1 || DIV > 65535) begin : g_bad_div
    $error("f_division: DIV must be in 1..65535");
  end else if (DIV == 1) begin : g_div1
    // A ratio of one is the input clock itself, gated low while in reset.
    assign clk_out = clk_in & rst;
  end else begin : g_divn
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pos_q, pos_d;

    always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      pos_d = (cnt_d != '0) && (cnt_d <= HALF);
    end

    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        pos_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        pos_q <= pos_d;
      end
    end

    if ((DIV % 2) == 0) begin : g_even
      assign clk_out = pos_q;
    end else begin : g_odd
      logic neg_q;

      // Half-cycle delayed copy stretches the high phase by T/2; it is still
      // high when pos_q falls, so the OR below cannot glitch.
      always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) neg_q <= 1'b0;
        else      neg_q <= pos_q;
      end

      assign clk_out = pos_q | neg_q;
    end
  end

endmodule

// File: tb/tb_f_division.sv
// Bench for f_division: DIV=1..5 run side by side, sampled every half clk_in
// period against a scoreboard of expected levels and clk_out rising-edge counts.
module tb_f_division;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b0;
  logic [5:1] co;
  logic       cnt_en = 1'b0;
  int         rises [5:1];
  int         checks = 0;
  int         errors = 0;
  logic [5:1] exp_q [$];

  always #5 clk_in = ~clk_in;

  for (genvar g = 1; g <= 5; g++) begin : g_dut
    f_division #(.DIV(g)) u_dut (
      .clk_in (clk_in),
      .rst    (rst),
      .clk_out(co[g])
    );

    always @(posedge co[g]) if (cnt_en) rises[g] = rises[g] + 1;
  end

  // Half-cycle h counts from the first clk_in rising edge after release;
  // clk_out is high during the first DIV half-cycles of every 2*DIV.
  function automatic logic exp_bit(int d, int h);
    return (h % (2 * d)) < d;
  endfunction

  task automatic release_rst();
    @(negedge clk_in);
    #1 rst = 1'b1;
  endtask

  task automatic check_all_low(string tag, int nh);
    for (int h = 0; h < nh; h++) begin
      if (h % 2 == 0) @(posedge clk_in); else @(negedge clk_in);
      #2;
      for (int d = 1; d <= 5; d++) begin
        checks++;
        if (co[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s div%0d h%0d: clk_out=%b required 0", tag, d, h, co[d]);
        end
      end
    end
  endtask

  task automatic run_window(string tag, int nh);
    logic [5:1] v;
    logic [5:1] e;
    int         want;
    for (int h = 0; h < nh; h++) begin
      for (int d = 1; d <= 5; d++) v[d] = exp_bit(d, h);
      exp_q.push_back(v);
    end
    for (int d = 1; d <= 5; d++) rises[d] = 0;
    cnt_en = 1'b1;
    for (int h = 0; h < nh; h++) begin
      if (h % 2 == 0) @(posedge clk_in); else @(negedge clk_in);
      #2;
      e = exp_q.pop_front();
      for (int d = 1; d <= 5; d++) begin
        checks++;
        if (co[d] !== e[d]) begin
          errors++;
          $display("FAIL %s div%0d h%0d: clk_out=%b required %b", tag, d, h, co[d], e[d]);
        end
      end
    end
    cnt_en = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      want = (nh + 2 * d - 1) / (2 * d);
      checks++;
      if (rises[d] != want) begin
        errors++;
        $display("FAIL %s_edges div%0d: rises=%0d required %0d", tag, d, rises[d], want);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    check_all_low("reset", 6);
  endtask

  // 200 half-cycles: 20 periods of DIV=5, 25 of DIV=4, 33 of DIV=3.
  task automatic test_divide();
    release_rst();
    run_window("divide", 200);
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    check_all_low("rst_hold", 4);
    release_rst();
    run_window("pre_cut", 1);
    // Between edges with clk_out high on every ratio: the cut needs no edge.
    #1 rst = 1'b0;
    #1;
    for (int d = 1; d <= 5; d++) begin
      checks++;
      if (co[d] !== 1'b0) begin
        errors++;
        $display("FAIL async_cut div%0d: clk_out=%b required 0", d, co[d]);
      end
    end
    check_all_low("cut_hold", 6);
    release_rst();
    run_window("resume", 80);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      rst = 1'b0;
      @(posedge clk_in);
      release_rst();
      run_window("b2b", 12 + 7 * r);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
